// File: rtl/simon_pixel_renderer.sv
// Simon pixel source: four quadrant outlines/fills plus a frame-timed
// flash sequencer with a one-at-a-time start/ready handshake.
module simon_pixel_renderer #(
    parameter int         GAP_PX     = 4,
    parameter int         BORDER_PX  = 6,
    parameter logic [5:0] GAP_FRAMES = 6'd8
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [8:0] x,
    input  logic [7:0] y,
    input  logic       start,
    input  logic [1:0] quad,
    input  logic [5:0] frames,
    output logic       ready,
    output logic       done,
    output logic [3:0] lit,
    output logic [2:0] color
);

    localparam logic [9:0] X_MID  = 10'd160;
    localparam logic [9:0] Y_MID  = 10'd120;
    localparam logic [9:0] X_END  = 10'd320;
    localparam logic [9:0] Y_END  = 10'd240;
    localparam logic [9:0] XG_LO  = 10'(160 - GAP_PX);
    localparam logic [9:0] XG_HI  = 10'(160 + GAP_PX);
    localparam logic [9:0] YG_LO  = 10'(120 - GAP_PX);
    localparam logic [9:0] YG_HI  = 10'(120 + GAP_PX);
    localparam logic [9:0] BW     = 10'(BORDER_PX);
    localparam logic [9:0] XL_IN  = 10'(160 - GAP_PX - BORDER_PX);
    localparam logic [9:0] XR_IN  = 10'(160 + GAP_PX + BORDER_PX);
    localparam logic [9:0] YT_IN  = 10'(120 - GAP_PX - BORDER_PX);
    localparam logic [9:0] YB_IN  = 10'(120 + GAP_PX + BORDER_PX);
    localparam logic [9:0] X_OUT  = 10'(320 - BORDER_PX);
    localparam logic [9:0] Y_OUT  = 10'(240 - BORDER_PX);

    typedef enum logic [1:0] {IDLE, LIT, GAP} state_t;

    state_t     state;
    logic [5:0] cnt;
    logic [7:0] y_prev;
    logic       frame_tick;

    logic [9:0] xw;
    logic [9:0] yw;
    logic       offscreen;
    logic       in_gap;
    logic       right;
    logic       bottom;
    logic [1:0] qidx;
    logic       edge_x;
    logic       edge_y;
    logic       outline;
    logic [2:0] qcol;
    logic [2:0] color_d;

    assign xw         = {1'b0, x};
    assign yw         = {2'b00, y};
    assign frame_tick = (y == 8'd0) && (y_prev != 8'd0);

    // Geometry: which quadrant, gap cross, and outline band the dot falls in
    always_comb begin
        offscreen = (xw >= X_END) || (yw >= Y_END);
        in_gap    = ((xw >= XG_LO) && (xw < XG_HI)) ||
                    ((yw >= YG_LO) && (yw < YG_HI));
        right     = (xw >= X_MID);
        bottom    = (yw >= Y_MID);
        qidx      = {bottom, right};
        edge_x    = right  ? ((xw < XR_IN) || (xw >= X_OUT))
                           : ((xw < BW)    || (xw >= XL_IN));
        edge_y    = bottom ? ((yw < YB_IN) || (yw >= Y_OUT))
                           : ((yw < BW)    || (yw >= YT_IN));
        outline   = edge_x || edge_y;
    end

    // Quadrant colour lookup
    always_comb begin
        qcol = 3'b000;
        unique case (qidx)
            2'd0: qcol = 3'b010;
            2'd1: qcol = 3'b100;
            2'd2: qcol = 3'b110;
            2'd3: qcol = 3'b001;
            default: qcol = 3'b000;
        endcase
    end

    // Colour priority: offscreen, gap, lit fill, outline, black
    always_comb begin
        color_d = 3'b000;
        if (offscreen || in_gap)
            color_d = 3'b000;
        else if (lit[qidx] || outline)
            color_d = qcol;
    end

    // Register pixel colour and previous row for frame edge detection
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            color  <= 3'b000;
            y_prev <= 8'd0;
        end else begin
            color  <= color_d;
            y_prev <= y;
        end
    end

    // Flash sequencer: accept, light for N frames, dark gap, then done
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 6'd0;
            ready <= 1'b1;
            done  <= 1'b0;
            lit   <= 4'b0000;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (start && ready) begin
                        ready <= 1'b0;
                        if (frames != 6'd0) begin
                            state <= LIT;
                            cnt   <= frames;
                            lit   <= 4'(1) << quad;
                        end else begin
                            state <= GAP;
                            cnt   <= GAP_FRAMES;
                        end
                    end
                end
                LIT: begin
                    if (frame_tick) begin
                        cnt <= 6'(cnt - 6'd1);
                        if (cnt == 6'd1) begin
                            state <= GAP;
                            cnt   <= GAP_FRAMES;
                            lit   <= 4'b0000;
                        end
                    end
                end
                GAP: begin
                    if (cnt == 6'd0 ||
                        (frame_tick && cnt == 6'd1)) begin
                        state <= IDLE;
                        cnt   <= 6'd0;
                        done  <= 1'b1;
                    end else if (frame_tick) begin
                        cnt <= 6'(cnt - 6'd1);
                    end
                end
                default: begin
                    state <= IDLE;
                    lit   <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_pixel_renderer.sv
// Self-checking bench for simon_pixel_renderer: geometry table,
// hand-written flash sequences and a random run against a tick-count model.
module tb_simon_pixel_renderer;

    localparam int G  = 8;
    localparam int GP = 4;
    localparam int B  = 6;

    logic       CLOCK_50;
    logic       resetn;
    logic [8:0] x;
    logic [7:0] y;
    logic       start;
    logic [1:0] quad;
    logic [5:0] frames;
    logic       ready;
    logic       done;
    logic [3:0] lit;
    logic [2:0] color;

    simon_pixel_renderer dut (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .x       (x),
        .y       (y),
        .start   (start),
        .quad    (quad),
        .frames  (frames),
        .ready   (ready),
        .done    (done),
        .lit     (lit),
        .color   (color)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    int passed;
    int total;

    // Model state: flash schedule expressed in frame-tick counts
    logic       m_ready;
    logic       m_done;
    logic [3:0] m_lit;
    logic       m_busy;
    logic       m_pend;
    int         m_yprev;
    int         m_ticks;
    int         m_lit_end;
    int         m_done_at;
    int         m_done_cnt;
    int         dut_done_cnt;

    typedef struct {
        int         vx;
        int         vy;
        logic [2:0] col;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                      name, act, exp, $time);
    endtask

    function automatic logic [2:0] ref_color(input int px, input int py,
                                             input logic [3:0] l);
        int q, x0, x1, y0, y1, d;
        logic [2:0] cols[4];
        cols[0] = 3'b010;
        cols[1] = 3'b100;
        cols[2] = 3'b110;
        cols[3] = 3'b001;
        if (px >= 320 || py >= 240) return 3'b000;
        if (px >= 160 - GP && px < 160 + GP) return 3'b000;
        if (py >= 120 - GP && py < 120 + GP) return 3'b000;
        q  = ((py >= 120) ? 2 : 0) + ((px >= 160) ? 1 : 0);
        x0 = (q % 2 == 1) ? 160 + GP : 0;
        x1 = (q % 2 == 1) ? 319 : 160 - GP - 1;
        y0 = (q >= 2) ? 120 + GP : 0;
        y1 = (q >= 2) ? 239 : 120 - GP - 1;
        d  = px - x0;
        if (x1 - px < d) d = x1 - px;
        if (py - y0 < d) d = py - y0;
        if (y1 - py < d) d = y1 - py;
        if (l[q] || d < B) return cols[q];
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_ready = 1'b1;
        m_done  = 1'b0;
        m_lit   = 4'b0000;
        m_busy  = 1'b0;
        m_pend  = 1'b0;
        m_yprev = 0;
        m_ticks = 0;
    endtask

    // One clock: advance the model at the edge, compare at the next negedge
    task automatic step();
        logic [3:0] lit_before;
        logic       r_before;
        logic       tk;
        logic [2:0] ecol;
        @(posedge CLOCK_50);
        lit_before = m_lit;
        r_before   = m_ready;
        tk         = (int'(y) == 0) && (m_yprev != 0);
        m_yprev    = int'(y);
        ecol       = ref_color(int'(x), int'(y), lit_before);
        m_done     = 1'b0;
        if (m_pend) begin
            m_ready = 1'b1;
            m_pend  = 1'b0;
        end
        if (m_busy) begin
            if (tk) begin
                m_ticks++;
                if (m_ticks == m_lit_end) m_lit = 4'b0000;
                if (m_ticks == m_done_at) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_pend = 1'b1;
                    m_done_cnt++;
                end
            end
        end else if (start && r_before) begin
            m_busy    = 1'b1;
            m_ready   = 1'b0;
            m_ticks   = 0;
            m_lit_end = int'(frames);
            m_done_at = int'(frames) + G;
            m_lit     = (frames != 0) ? (4'b0001 << quad) : 4'b0000;
        end
        @(negedge CLOCK_50);
        chk("ready", int'(ready), int'(m_ready));
        chk("done",  int'(done),  int'(m_done));
        chk("lit",   int'(lit),   int'(m_lit));
        chk("color", int'(color), int'(ecol));
        if (done) dut_done_cnt++;
    endtask

    task automatic tick();
        y = 8'd50;
        step();
        y = 8'd0;
        step();
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        m_done_cnt   = 0;
        dut_done_cnt = 0;
        vecs[0]  = '{3,   3,   3'b010};
        vecs[1]  = '{80,  60,  3'b000};
        vecs[2]  = '{160, 60,  3'b000};
        vecs[3]  = '{310, 235, 3'b001};
        vecs[4]  = '{330, 10,  3'b000};
        vecs[5]  = '{155, 10,  3'b010};
        vecs[6]  = '{156, 10,  3'b000};
        vecs[7]  = '{164, 10,  3'b100};
        vecs[8]  = '{170, 10,  3'b000};
        vecs[9]  = '{200, 3,   3'b100};
        vecs[10] = '{3,   200, 3'b110};
        vecs[11] = '{80,  119, 3'b000};
        vecs[12] = '{80,  115, 3'b010};
        vecs[13] = '{80,  124, 3'b110};
        vecs[14] = '{319, 100, 3'b100};
        vecs[15] = '{0,   239, 3'b110};
        vecs[16] = '{100, 240, 3'b000};
        vecs[17] = '{399, 262, 3'b000};

        resetn = 1'b1;
        x      = '0;
        y      = '0;
        start  = 1'b0;
        quad   = 2'd0;
        frames = 6'd0;
        model_reset();
        #5 resetn = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done",  int'(done),  0);
        chk("rst_lit",   int'(lit),   0);
        chk("rst_color", int'(color), 0);
        resetn = 1'b1;

        // Geometry table, nothing lit
        foreach (vecs[i]) begin
            x = 9'(vecs[i].vx);
            y = 8'(vecs[i].vy);
            step();
            chk($sformatf("tbl%0d", i), int'(color), int'(vecs[i].col));
        end

        // Flash yellow for 3 frames, accepted mid-frame
        step();
        y = 8'd50;
        step();
        start  = 1'b1;
        quad   = 2'd2;
        frames = 6'd3;
        step();
        start = 1'b0;
        chk("a_ready", int'(ready), 0);
        chk("a_lit",   int'(lit),   4'b0100);
        x = 9'd80;
        y = 8'd180;
        step();
        chk("a_fill", int'(color), 3'b110);
        tick();
        tick();
        chk("a_lit2", int'(lit), 4'b0100);
        tick();
        chk("a_lit3", int'(lit), 0);
        for (int i = 0; i < G - 1; i++) tick();
        chk("a_nodone", int'(done),  0);
        chk("a_busy",   int'(ready), 0);
        tick();
        chk("a_done",    int'(done),  1);
        chk("a_notrdy",  int'(ready), 0);
        step();
        chk("a_done_lo", int'(done),  0);
        chk("a_rdy",     int'(ready), 1);

        // start held high with changing quad/frames
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            quad   = 2'($urandom_range(0, 3));
            frames = 6'($urandom_range(1, 3));
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        step();
        chk("b_done_cnt", dut_done_cnt, m_done_cnt);

        // Zero-length flash: dark gap only
        start  = 1'b1;
        quad   = 2'd3;
        frames = 6'd0;
        step();
        start = 1'b0;
        chk("z_lit", int'(lit), 0);
        for (int i = 0; i < G - 1; i++) tick();
        chk("z_nodone", int'(done), 0);
        tick();
        chk("z_done", int'(done), 1);
        step();

        // y held at 0 freezes the frame count
        y      = 8'd50;
        start  = 1'b1;
        quad   = 2'd1;
        frames = 6'd2;
        step();
        start = 1'b0;
        y     = 8'd0;
        for (int i = 0; i < 50; i++) step();
        chk("h_lit", int'(lit), 4'b0010);
        tick();
        chk("h_lit_off", int'(lit), 0);
        for (int i = 0; i < G; i++) tick();
        step();

        // Reset in the middle of a flash
        y      = 8'd50;
        start  = 1'b1;
        quad   = 2'd0;
        frames = 6'd9;
        step();
        start = 1'b0;
        x     = 9'd3;
        for (int i = 0; i < 4; i++) tick();
        resetn = 1'b0;
        #1;
        chk("r_lit",   int'(lit),   0);
        chk("r_ready", int'(ready), 1);
        chk("r_color", int'(color), 0);
        chk("r_done",  int'(done),  0);
        model_reset();
        @(negedge CLOCK_50);
        resetn = 1'b1;
        start  = 1'b1;
        quad   = 2'd0;
        frames = 6'd1;
        step();
        start = 1'b0;
        chk("r_relit", int'(lit), 4'b0001);
        for (int i = 0; i < G + 1; i++) tick();
        step();

        // Random run
        for (int i = 0; i < 600; i++) begin
            x      = 9'($urandom_range(0, 399));
            y      = ($urandom_range(0, 3) == 0) ? 8'd0
                     : 8'($urandom_range(1, 262));
            start  = 1'($urandom_range(0, 1));
            quad   = 2'($urandom_range(0, 3));
            frames = 6'($urandom_range(0, 4));
            step();
        end
        start = 1'b0;
        chk("rnd_done_cnt", dut_done_cnt, m_done_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
